pipe_ctrl: RTL

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 34 +++
 rtl/stall_wdog.sv | 42 ++++
 rtl/pipe_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the pipeline controller: stop/no-stop levels,
// MEM-stage exception codes, FSM state encodings and per-depth stall patterns.
`ifndef PIPE_CTRL_DEFINES
`define PIPE_CTRL_DEFINES
`define STOP            1'b1
`define NOSTOP          1'b0
`define EXC_CODE_WIDTH  5
`define EC_NONE         5'h00
`define EC_SYSCALL      5'h08
`define EC_OVERFLOW     5'h0c
`define EC_ERET         5'h0e
`define ST_RUN          2'b00
`define ST_FLUSH        2'b01
`define ST_RECOVER      2'b10
`endif

package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN     = `ST_RUN,
        FLUSH   = `ST_FLUSH,
        RECOVER = `ST_RECOVER
    } state_e;

    typedef logic [`EXC_CODE_WIDTH-1:0] exc_code_t;

    // Stall vectors, bit0 = PC ... bit5 = WB; a stopped stage also stops everything upstream.
    localparam logic [5:0] STALL_NONE = {6{`NOSTOP}};
    localparam logic [5:0] STALL_IF   = {{4{`NOSTOP}}, {2{`STOP}}};
    localparam logic [5:0] STALL_ID   = {{3{`NOSTOP}}, {3{`STOP}}};
    localparam logic [5:0] STALL_EX   = {{2{`NOSTOP}}, {4{`STOP}}};
    localparam logic [5:0] STALL_MEM  = {`NOSTOP, {5{`STOP}}};

endpackage

// File: rtl/stall_wdog.sv
// Consecutive-stall watchdog: counts cycles with any stage stopped and raises a
// sticky timeout once the run length reaches LIMIT. Built only with PIPE_CTRL_WDOG_EN.
module stall_wdog #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic stall_active,
    output logic stall_timeout
);

    localparam logic [7:0] LIMIT_C = 8'(LIMIT);

    logic [7:0] cnt_q, cnt_d;
    logic       timeout_q, timeout_d;

    // NOTE: every variable gets a default before any branch, so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_d     = 8'd0;
        timeout_d = timeout_q;
        if (stall_active) begin
            cnt_d = (cnt_q == LIMIT_C) ? cnt_q : cnt_q + 8'd1;
            if (cnt_d == LIMIT_C) begin
                timeout_d = 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign stall_timeout = timeout_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: priority stall encoder plus RUN/FLUSH/RECOVER exception FSM.
// Define PIPE_CTRL_WDOG_EN to build in the consecutive-stall watchdog (stall_wdog).
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
    parameter int          WDOG_LIMIT = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stallreq_if,
    input  logic                       stallreq_id,
    input  logic                       stallreq_ex,
    input  logic                       stallreq_mem,
    input  logic [`EXC_CODE_WIDTH-1:0] exc_code_i,
    input  logic [31:0]                exc_pc_i,
    output logic [5:0]                 stall,
    output logic                       flush,
    output logic [31:0]                new_pc,
    output logic [31:0]                epc_o,
    output logic                       busy,
    output logic                       stall_timeout
);

    if (WDOG_LIMIT < 1 || WDOG_LIMIT > 255) begin : g_bad_wdog_limit
        $error("pipe_ctrl: WDOG_LIMIT must fit the 8-bit watchdog counter (1..255)");
    end

    state_e      state_q, state_d;
    logic [31:0] epc_q, epc_d;
    logic [5:0]  stall_req;
    logic [5:0]  stall_c;
    logic        flush_c;
    logic [31:0] new_pc_c;

    always_comb begin
        stall_req = STALL_NONE;
        if (stallreq_mem) begin
            stall_req = STALL_MEM;
        end else if (stallreq_ex) begin
            stall_req = STALL_EX;
        end else if (stallreq_id) begin
            stall_req = STALL_ID;
        end else if (stallreq_if) begin
            stall_req = STALL_IF;
        end
    end

    // Exceptions are only accepted in RUN; FLUSH carries wrong-path state and is ignored.
    always_comb begin
        state_d  = state_q;
        epc_d    = epc_q;
        stall_c  = STALL_NONE;
        flush_c  = 1'b0;
        new_pc_c = 32'h0;
        case (state_q)
            RUN: begin
                if (exc_code_i != `EC_NONE) begin
                    flush_c = 1'b1;
                    state_d = FLUSH;
                    if (exc_code_i == `EC_ERET) begin
                        new_pc_c = epc_q;
                    end else begin
                        new_pc_c = EXC_VECTOR;
                        epc_d    = exc_pc_i;
                    end
                end else begin
                    stall_c = stall_req;
                end
            end
            FLUSH: begin
                state_d = RECOVER;
            end
            RECOVER: begin
                stall_c = stall_req;
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            epc_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            epc_q   <= epc_d;
        end
    end

    // Reset forces all control outputs quiet even while requests are still asserted.
    assign stall  = rst ? STALL_NONE : stall_c;
    assign flush  = rst ? 1'b0 : flush_c;
    assign new_pc = rst ? 32'h0 : new_pc_c;
    assign busy   = !rst && (state_q != RUN);
    assign epc_o  = epc_q;

`ifdef PIPE_CTRL_WDOG_EN
    stall_wdog #(
        .LIMIT(WDOG_LIMIT)
    ) u_stall_wdog (
        .clk          (clk),
        .rst          (rst),
        .stall_active (|stall),
        .stall_timeout(stall_timeout)
    );
`else
    assign stall_timeout = 1'b0;
`endif

endmodule
